// File: rtl/oscilo_pkg.sv
// Shared definitions for the oscilloscope controller blocks.
//   - command codes decoded by the main state watcher
//   - sample_reader state encoding
//   - sample_t: one sample word, the same width as a UART byte
package oscilo_pkg;

    localparam logic [7:0] CMD_TEST        = 8'h11;
    localparam logic [7:0] CMD_SAMPLER     = 8'h21;
    localparam logic [7:0] CMD_SAMPLE_READ = 8'h22;
    localparam logic [7:0] CMD_REPLAYER    = 8'h71;
    localparam logic [7:0] CMD_REPLY_CNT   = 8'h72;

    localparam int SAMPLE_WIDTH = 8;
    typedef logic [SAMPLE_WIDTH-1:0] sample_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        NEXT  = 3'd4,
        FIN   = 3'd5
    } sr_state_e;

endpackage

// File: rtl/sample_reader_if.sv
// Bus bundle around sample_reader: the activate/done handshake with the
// state watcher, the asynchronous read port of the sample RAM, and the
// UART_TX manager byte interface.
//   master : the reader (drives done, mem_addr, mem_oe, tx_data, tx_start)
//   slave  : the environment (drives activate, mem_data, tx_active, tx_done)
interface sample_reader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  activate;
    logic                  done;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_oe;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [7:0]            tx_data;
    logic                  tx_start;
    logic                  tx_active;
    logic                  tx_done;

    modport master (
        input  activate, mem_data, tx_active, tx_done,
        output done, mem_addr, mem_oe, tx_data, tx_start
    );

    modport slave (
        output activate, mem_data, tx_active, tx_done,
        input  done, mem_addr, mem_oe, tx_data, tx_start
    );
endinterface

// File: rtl/sample_reader_tx_byte_issuer.sv
// tx_byte_issuer: one-byte start/finish handshake with the UART_TX manager.
// Shared by sample_reader, replayer and reply_cnt.
//   clk, reset : system clock, async active-high reset
//   req        : caller has a byte ready on tx_data (level)
//   abort      : caller is abandoning the transfer; drop any pending byte
//   tx_active  : UART busy
//   tx_done    : UART end-of-byte pulse
//   tx_start   : registered one-cycle start pulse to the UART
//   issued     : this cycle commits a start (tx_start follows next cycle)
//   byte_sent  : the byte we started has finished
module tx_byte_issuer (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic abort,
    input  logic tx_active,
    input  logic tx_done,
    output logic tx_start,
    output logic issued,
    output logic byte_sent
);
    logic busy_q, busy_d;
    logic tx_start_q, tx_start_d;

    // busy_q tracks "our byte is in the UART"; a tx_done outside that window
    // belongs to nobody and is ignored.
    always_comb begin
        issued     = req && !busy_q && !tx_active && !abort;
        byte_sent  = busy_q && tx_done && !abort;
        tx_start_d = issued;
        busy_d     = busy_q;
        if (issued) begin
            busy_d = 1'b1;
        end else if (byte_sent || abort) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q     <= 1'b0;
            tx_start_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            tx_start_q <= tx_start_d;
        end
    end

    assign tx_start = tx_start_q;

endmodule

// File: rtl/sample_reader.sv
// sample_reader: streams the sample RAM to the host as one frame
//   HEADER_BYTE, RAM[0..DEPTH-1], optional XOR-of-samples checksum.
// Runs under the state watcher at CMD_SAMPLE_READ with activate/done.
//   clk, reset : system clock, async active-high reset
//   bus        : sample_reader_if.master (handshake, RAM read port, UART tx)
//
// state | meaning
// IDLE  | waiting for activate; frame counters cleared on start
// HDR   | header byte loaded into tx_data
// ISSUE | waiting for the UART to be idle, then start the byte
// WAIT  | byte in flight, waiting for tx_done
// NEXT  | read next sample (or checksum) into tx_data, or finish
// FIN   | frame sent, done=1 until activate falls
module sample_reader
    import oscilo_pkg::*;
#(
    parameter int         DATA_WIDTH    = 8,
    parameter int         ADDR_WIDTH    = 8,
    parameter int         DEPTH         = 256,
    parameter logic [7:0] HEADER_BYTE   = CMD_SAMPLE_READ,
    parameter bit         SEND_CHECKSUM = 1'b1
) (
    input logic             clk,
    input logic             reset,
    sample_reader_if.master bus
);
    // One extra bit so DEPTH = 2**ADDR_WIDTH is reachable.
    localparam int            CW      = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    sr_state_e             state_q, state_d;
    logic                  done_q, done_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_oe_q, mem_oe_d;
    sample_t               checksum_q, checksum_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  cks_sent_q, cks_sent_d;

    logic                  issue_req;
    logic                  issued;
    logic                  byte_sent;
    logic                  abort;
    logic [DATA_WIDTH-1:0] sample_in;

    assign abort     = !bus.activate;
    assign issue_req = (state_q == ISSUE);
    assign sample_in = bus.mem_data;

    tx_byte_issuer u_issuer (
        .clk       (clk),
        .reset     (reset),
        .req       (issue_req),
        .abort     (abort),
        .tx_active (bus.tx_active),
        .tx_done   (bus.tx_done),
        .tx_start  (bus.tx_start),
        .issued    (issued),
        .byte_sent (byte_sent)
    );

    always_comb begin
        state_d    = state_q;
        done_d     = done_q;
        tx_data_d  = tx_data_q;
        mem_addr_d = mem_addr_q;
        mem_oe_d   = 1'b0;
        checksum_d = checksum_q;
        count_d    = count_q;
        cks_sent_d = cks_sent_q;

        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (bus.activate) begin
                    count_d    = '0;
                    checksum_d = '0;
                    mem_addr_d = '0;
                    cks_sent_d = 1'b0;
                    state_d    = HDR;
                end
            end
            HDR: begin
                tx_data_d = HEADER_BYTE;
                state_d   = ISSUE;
            end
            ISSUE: begin
                if (issued) state_d = WAIT;
            end
            WAIT: begin
                if (byte_sent) begin
                    state_d = NEXT;
                    // mem_oe is registered, so raise it on entry to a reading NEXT.
                    mem_oe_d = (count_q < DEPTH_C);
                end
            end
            NEXT: begin
                if (count_q < DEPTH_C) begin
                    // RAM read is asynchronous: mem_data belongs to mem_addr_q now.
                    tx_data_d  = 8'(sample_in);
                    checksum_d = checksum_q ^ sample_t'(sample_in);
                    mem_addr_d = mem_addr_q + 1'b1;
                    count_d    = count_q + 1'b1;
                    state_d    = ISSUE;
                end else if (SEND_CHECKSUM && !cks_sent_q) begin
                    tx_data_d  = 8'(checksum_q);
                    cks_sent_d = 1'b1;
                    state_d    = ISSUE;
                end else begin
                    done_d  = 1'b1;
                    state_d = FIN;
                end
            end
            FIN: begin
                if (!bus.activate) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Losing activate anywhere abandons the frame; a byte already in the
        // UART finishes on its own and its tx_done is ignored.
        if (abort) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            mem_oe_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            tx_data_q  <= '0;
            mem_addr_q <= '0;
            mem_oe_q   <= 1'b0;
            checksum_q <= '0;
            count_q    <= '0;
            cks_sent_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            tx_data_q  <= tx_data_d;
            mem_addr_q <= mem_addr_d;
            mem_oe_q   <= mem_oe_d;
            checksum_q <= checksum_d;
            count_q    <= count_d;
            cks_sent_q <= cks_sent_d;
        end
    end

    assign bus.done     = done_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_oe   = mem_oe_q;

endmodule

// File: tb/tb_sample_reader.sv
// Bench for sample_reader. Three instances:
//   0: DEPTH=4,   checksum on
//   1: DEPTH=4,   checksum off
//   2: DEPTH=256, checksum on
// A UART model per instance logs every started byte; the expected frame is
// rebuilt from the RAM contents as a list of bytes.
module tb_sample_reader;
    import oscilo_pkg::*;

    localparam int N_INST = 3;
    localparam int LOG_SZ = 1024;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    logic       act        [N_INST] = '{default: 1'b0};
    logic       force_busy [N_INST] = '{default: 1'b0};
    int         byte_time  [N_INST] = '{default: 10};
    logic [7:0] ram        [N_INST][256];

    // UART model state
    logic       busy_r    [N_INST] = '{default: 1'b0};
    logic       tx_done_r [N_INST] = '{default: 1'b0};
    int         left      [N_INST] = '{default: 0};
    logic [7:0] cur_byte  [N_INST] = '{default: 8'h00};
    logic [7:0] log_mem   [N_INST][LOG_SZ];
    int         log_n     [N_INST] = '{default: 0};
    int         done_cnt  [N_INST] = '{default: 0};
    int         oe_cnt    [N_INST] = '{default: 0};
    int         overrun   [N_INST] = '{default: 0};
    int         unstable  [N_INST] = '{default: 0};

    logic       done_w     [N_INST];
    logic       tx_start_w [N_INST];
    logic       mem_oe_w   [N_INST];
    logic [7:0] tx_data_w  [N_INST];
    logic [7:0] mem_addr_w [N_INST];

    for (genvar g = 0; g < N_INST; g++) begin : g_dut
        localparam int DEP = (g == 2) ? 256 : 4;
        localparam bit CKS = (g == 1) ? 1'b0 : 1'b1;

        sample_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) u_if ();

        assign u_if.activate  = act[g];
        assign u_if.mem_data  = ram[g][u_if.mem_addr];
        assign u_if.tx_active = busy_r[g] | force_busy[g];
        assign u_if.tx_done   = tx_done_r[g];
        assign done_w[g]      = u_if.done;
        assign tx_start_w[g]  = u_if.tx_start;
        assign mem_oe_w[g]    = u_if.mem_oe;
        assign tx_data_w[g]   = u_if.tx_data;
        assign mem_addr_w[g]  = u_if.mem_addr;

        sample_reader #(
            .DATA_WIDTH    (8),
            .ADDR_WIDTH    (8),
            .DEPTH         (DEP),
            .HEADER_BYTE   (8'h22),
            .SEND_CHECKSUM (CKS)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (u_if.master)
        );
    end

    // UART transmitter model: byte_time cycles busy, then a one-cycle tx_done.
    always @(posedge clk) begin
        for (int i = 0; i < N_INST; i++) begin
            tx_done_r[i] <= 1'b0;
            if (mem_oe_w[i]) oe_cnt[i] <= oe_cnt[i] + 1;
            if (tx_start_w[i]) begin
                if (busy_r[i] || force_busy[i]) overrun[i] <= overrun[i] + 1;
                log_mem[i][log_n[i] % LOG_SZ] <= tx_data_w[i];
                log_n[i]    <= log_n[i] + 1;
                cur_byte[i] <= tx_data_w[i];
                busy_r[i]   <= 1'b1;
                left[i]     <= byte_time[i];
            end else if (busy_r[i]) begin
                if (act[i] && tx_data_w[i] != cur_byte[i]) unstable[i] <= unstable[i] + 1;
                if (left[i] <= 1) begin
                    busy_r[i]    <= 1'b0;
                    tx_done_r[i] <= 1'b1;
                    done_cnt[i]  <= done_cnt[i] + 1;
                end else begin
                    left[i] <= left[i] - 1;
                end
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int depth_of(input int i);
        return (i == 2) ? 256 : 4;
    endfunction

    function automatic bit cks_of(input int i);
        return (i != 1);
    endfunction

    typedef struct {
        int         inst;
        int         mode;      // 0: 10,20,30,40  1: RAM[k]=k  2: random
        int         bt;        // UART byte time, 0 = random
        int         hold;      // cycles of forced tx_active at start
        int         exp_len;
        logic [7:0] exp_last;
        bit         last_known;
        logic [7:0] exp_addr;
    } vec_t;

    task automatic run_frame(input vec_t v);
        int         i;
        int         base, dbase, obase, last_txd, done_cyc;
        logic [7:0] x;
        logic [7:0] exp_q[$];
        i = v.inst;
        for (int k = 0; k < 256; k++) begin
            if (v.mode == 0)      ram[i][k] = (k < 4) ? 8'((k + 1) * 16) : 8'hEE;
            else if (v.mode == 1) ram[i][k] = 8'(k);
            else                  ram[i][k] = 8'($urandom_range(0, 255));
        end
        byte_time[i] = (v.bt == 0) ? int'($urandom_range(2, 14)) : v.bt;

        exp_q = {};
        exp_q.push_back(8'h22);
        x = 8'h00;
        for (int k = 0; k < depth_of(i); k++) begin
            exp_q.push_back(ram[i][k]);
            x = x ^ ram[i][k];
        end
        if (cks_of(i)) exp_q.push_back(x);

        @(negedge clk);
        base  = log_n[i];
        dbase = done_cnt[i];
        obase = oe_cnt[i];
        if (v.hold > 0) force_busy[i] = 1'b1;
        act[i] = 1'b1;
        if (v.hold > 0) begin
            repeat (v.hold) @(negedge clk);
            check($sformatf("hold_off_start[%0d]", i), log_n[i] - base, 0);
            force_busy[i] = 1'b0;
        end

        last_txd = -100;
        done_cyc = -1;
        for (int c = 0; c < 20000 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (tx_done_r[i]) last_txd = c;
            if (done_w[i]) done_cyc = c;
        end
        check($sformatf("done_timeout[%0d]", i), 32'(done_cyc >= 0), 1);
        check($sformatf("done_latency[%0d]", i), done_cyc - last_txd, 2);
        check($sformatf("tx_done_count[%0d]", i), done_cnt[i] - dbase, v.exp_len);

        repeat (30) @(negedge clk);
        check($sformatf("frame_len[%0d]", i), log_n[i] - base, v.exp_len);
        check($sformatf("frame_len_model[%0d]", i), log_n[i] - base, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            check($sformatf("byte[%0d][%0d]", i, k), log_mem[i][(base + k) % LOG_SZ], exp_q[k]);
        if (v.last_known)
            check($sformatf("last_byte[%0d]", i), log_mem[i][(base + v.exp_len - 1) % LOG_SZ], v.exp_last);
        check($sformatf("done_held[%0d]", i), done_w[i], 1);
        check($sformatf("mem_addr_final[%0d]", i), mem_addr_w[i], v.exp_addr);
        check($sformatf("mem_oe_cycles[%0d]", i), oe_cnt[i] - obase, depth_of(i));

        act[i] = 1'b0;
        @(negedge clk);
        check($sformatf("done_clear[%0d]", i), done_w[i], 0);
        @(negedge clk);
    endtask

    vec_t vecs[7];

    initial begin : main
        int  base, dbase;
        bit  seen, done_seen;

        vecs[0] = '{0, 0, 10,  0,   6, 8'h40, 1'b1, 8'h04};
        vecs[1] = '{1, 0, 10,  0,   5, 8'h40, 1'b1, 8'h04};
        vecs[2] = '{2, 1, 10,  0, 258, 8'h00, 1'b1, 8'h00};
        vecs[3] = '{0, 2,  0,  0,   6, 8'h00, 1'b0, 8'h04};
        vecs[4] = '{1, 2,  0, 50,   5, 8'h00, 1'b0, 8'h04};
        vecs[5] = '{0, 0, 10, 50,   6, 8'h40, 1'b1, 8'h04};
        vecs[6] = '{2, 2,  0,  0, 258, 8'h00, 1'b0, 8'h00};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N_INST; i++) begin
            check($sformatf("rst_done[%0d]", i), done_w[i], 0);
            check($sformatf("rst_tx_start[%0d]", i), tx_start_w[i], 0);
            check($sformatf("rst_tx_data[%0d]", i), tx_data_w[i], 0);
            check($sformatf("rst_mem_addr[%0d]", i), mem_addr_w[i], 0);
            check($sformatf("rst_mem_oe[%0d]", i), mem_oe_w[i], 0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 7; v++) run_frame(vecs[v]);

        // Abort after the second tx_done.
        byte_time[0] = 10;
        @(negedge clk);
        base  = log_n[0];
        dbase = done_cnt[0];
        act[0] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (done_cnt[0] - dbase >= 2) seen = 1'b1;
        end
        check("abort_reached", 32'(seen), 1);
        act[0] = 1'b0;
        done_seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done_w[0]) done_seen = 1'b1;
        end
        check("abort_starts", log_n[0] - base, 2);
        check("abort_no_done", 32'(done_seen), 0);
        check("abort_mem_oe", mem_oe_w[0], 0);
        check("abort_tx_start", tx_start_w[0], 0);
        run_frame(vecs[0]);

        // Reset while the second byte is in flight.
        byte_time[0] = 12;
        @(negedge clk);
        base = log_n[0];
        act[0] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (log_n[0] - base >= 2) seen = 1'b1;
        end
        check("rst_wait_reached", 32'(seen), 1);
        repeat (3) @(negedge clk);
        reset  = 1'b1;
        act[0] = 1'b0;
        #1;
        check("rstmid_tx_data", tx_data_w[0], 0);
        check("rstmid_mem_addr", mem_addr_w[0], 0);
        check("rstmid_tx_start", tx_start_w[0], 0);
        check("rstmid_done", done_w[0], 0);
        check("rstmid_mem_oe", mem_oe_w[0], 0);
        @(negedge clk);
        reset = 1'b0;
        base  = log_n[0];
        dbase = done_cnt[0];
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (done_cnt[0] > dbase) seen = 1'b1;
        end
        check("spurious_tx_done_seen", 32'(seen), 1);
        repeat (10) @(negedge clk);
        check("spurious_no_start", log_n[0] - base, 0);
        check("spurious_no_done", done_w[0], 0);

        for (int i = 0; i < N_INST; i++) begin
            check($sformatf("overrun[%0d]", i), overrun[i], 0);
            check($sformatf("unstable_tx_data[%0d]", i), unstable[i], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
